add_result_stage: RTL and testbench

//   Registered operand/result stage around a WIDTH-bit ripple-carry adder datapath.

---
 rtl/add_result_stage.sv | 164 ++++++++++++++++
 tb/tb_add_result_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_result_stage.sv
// Registered operand/result stage around a WIDTH-bit ripple-carry adder with an
// accumulator and stored carry. Optional result saturation: define ADD_STAGE_SAT_EN.
module add_result_stage #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic [2:0]       op_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [3:0]       out_flags,
  output logic [WIDTH-1:0] acc_value,
  output logic             dbg_state
);

  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_ACC = 3'b010;
  localparam logic [2:0] MODE_ADC = 3'b011;
  localparam logic [2:0] MODE_CLR = 3'b100;

  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      r_state;
  slot_state_t      w_next_state;
  logic             w_accept;
  logic             w_drain;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;

  logic             w_is_acc;
  logic             w_is_clr;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_ci;
  logic [WIDTH-1:0] w_raw_sum;
  logic             w_raw_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_arith_res;
  logic [WIDTH-1:0] w_res;
  logic             w_res_cout;
  logic             w_res_ovf;
  logic [3:0]       w_res_flags;

  // Handshake: a beat transfers on in_valid & in_ready, a result on out_valid & out_ready.
  // in_ready depends only on slot state and out_ready, so a full slot that drains
  // in the same cycle takes a new beat with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = (r_state == S_EMPTY) | out_ready;
    w_accept     = in_valid & in_ready;
    w_drain      = (r_state == S_FULL) & out_ready;
    case (r_state)
      S_EMPTY: if (w_accept) w_next_state = S_FULL;
      S_FULL:  if (w_drain && !w_accept) w_next_state = S_EMPTY;
      default: w_next_state = S_EMPTY;
    endcase
  end

  assign w_is_acc = (op_mode == MODE_ACC);
  assign w_is_clr = (op_mode == MODE_CLR);

  // Unlisted opcodes fall through to the ADD forming.
  always_comb begin
    w_a  = op_a;
    w_b  = op_b;
    w_ci = op_cin;
    case (op_mode)
      MODE_SUB: begin
        w_b  = ~op_b;
        w_ci = 1'b1;
      end
      MODE_ACC: begin
        w_a  = r_acc;
        w_ci = 1'b0;
      end
      MODE_ADC: w_ci = r_carry;
      default:  ;
    endcase
  end

  always_comb begin : ripple
    logic c;
    w_raw_sum = '0;
    c         = w_ci;
    for (int i = 0; i < WIDTH; i++) begin
      w_raw_sum[i] = w_a[i] ^ w_b[i] ^ c;
      c            = (w_a[i] & w_b[i]) | (c & (w_a[i] ^ w_b[i]));
    end
    w_raw_cout = c;
  end

  assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_raw_sum[WIDTH-1] != w_a[WIDTH-1]);

`ifdef ADD_STAGE_SAT_EN
  // Clamp direction follows the sign of the formed A operand.
  assign w_arith_res = w_ovf ? (w_a[WIDTH-1] ? SIGNED_MIN : SIGNED_MAX) : w_raw_sum;
`else
  assign w_arith_res = w_raw_sum;
`endif

  assign w_res       = w_is_clr ? ACC_INIT : w_arith_res;
  assign w_res_cout  = w_is_clr ? 1'b0 : w_raw_cout;
  assign w_res_ovf   = w_is_clr ? 1'b0 : w_ovf;
  assign w_res_flags = {w_res[WIDTH-1], (w_res == '0), w_res_cout, w_res_ovf};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_flags <= '0;
      r_acc   <= ACC_INIT;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_sum   <= w_res;
      r_cout  <= w_res_cout;
      r_flags <= w_res_flags;
      if (w_is_clr) begin
        r_acc   <= ACC_INIT;
        r_carry <= 1'b0;
      end else begin
        r_carry <= w_raw_cout;
        if (w_is_acc) r_acc <= w_arith_res;
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_flags = r_flags;
  assign acc_value = r_acc;
  assign dbg_state = r_state;

  // Unused on purpose: SIGNED_MAX/MIN only matter in the saturating build.
  logic w_unused_consts;
  assign w_unused_consts = ^{SIGNED_MAX, SIGNED_MIN};

endmodule

// File: tb/tb_add_result_stage.sv
// Self-checking bench for add_result_stage: directed corner cases plus randomized
// traffic against an arithmetic reference model and an expected-result queue.
module tb_add_result_stage;

  localparam int W = 32;
`ifdef ADD_STAGE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [2:0]   op_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic [3:0]   out_flags;
  logic [W-1:0] acc_value;
  logic         dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  bit rand_ready = 1'b0;

  // Scoreboard entries are {sum, cout, flags}.
  logic [W+4:0] exp_q[$];
  logic [W-1:0] m_acc;
  logic         m_carry;

  add_result_stage #(.WIDTH(W), .ACC_INIT('0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_mode(op_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_flags(out_flags),
    .acc_value(acc_value), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operation's meaning.
  function automatic logic [W+4:0] ref_eval(input logic [2:0] mode, input logic [W-1:0] a_in,
                                            input logic [W-1:0] b_in, input logic cin,
                                            input logic [W-1:0] acc, input logic carry);
    longint unsigned ua, ub, us;
    longint sa, sb, ss;
    logic [W-1:0] res;
    logic c, v, a_neg;
    ua = a_in; ub = b_in; sa = $signed(a_in); sb = $signed(b_in); a_neg = a_in[W-1];
    case (mode)
      3'd1: begin
        us = ua - ub; c = (ua >= ub); ss = sa - sb;
      end
      3'd2: begin
        ua = acc; sa = $signed(acc); a_neg = acc[W-1];
        us = ua + ub; c = us[W]; ss = sa + sb;
      end
      3'd3: begin
        us = ua + ub + carry; c = us[W]; ss = sa + sb + carry;
      end
      3'd4: return {32'h0, 1'b0, 4'b0100};
      default: begin
        us = ua + ub + cin; c = us[W]; ss = sa + sb + cin;
      end
    endcase
    res = us[W-1:0];
    v = (ss > SMAX) || (ss < SMIN);
    if (SAT && v) res = a_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {res, c, res[W-1], (res == 0), c, v};
  endfunction

  // Monitor/scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [W+4:0] r;
    if (rst) begin
      exp_q.delete();
      m_acc   = '0;
      m_carry = 1'b0;
    end else begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("dbg_state", dbg_state, exp_q.size() != 0);
      chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
      chk("acc_value", acc_value, m_acc);
      if (out_valid && exp_q.size() != 0) begin
        chk("sb_sum", out_sum, exp_q[0][W+4:5]);
        chk("sb_cout", out_cout, exp_q[0][4]);
        chk("sb_flags", out_flags, exp_q[0][3:0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && (exp_q.size() == 0 || out_ready || !out_valid) && in_ready) begin
        r = ref_eval(op_mode, op_a, op_b, op_cin, m_acc, m_carry);
        exp_q.push_back(r);
        if (op_mode == 3'd4) begin
          m_acc = '0; m_carry = 1'b0;
        end else begin
          m_carry = r[4];
          if (op_mode == 3'd2) m_acc = r[W+4:5];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin);
    int  budget;
    logic took;
    op_mode = mode; op_a = a; op_b = b; op_cin = cin; in_valid = 1'b1;
    budget = 0; took = 1'b0;
    while (!took && budget < 64) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      budget++;
    end
    in_valid = 1'b0;
    if (!took) chk("accept_timeout", 0, 1);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] s, input logic c,
                         input logic [3:0] f);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_cout"}, out_cout, c);
    chk({tag, "_flags"}, out_flags, f);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    time t0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; op_mode = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", out_cout, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_acc", acc_value, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("empty_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    send(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    chk_res("add_wrap", 32'h0, 1'b1, 4'b0110);
    send(3'd1, 32'h5, 32'h7, 1'b0);
    chk_res("sub_neg", 32'hFFFF_FFFE, 1'b0, 4'b1000);
    send(3'd1, 32'h8000_0000, 32'h1, 1'b0);
    chk_res("sub_ovf", SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, SAT ? 4'b1011 : 4'b0011);

    send(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    send(3'd3, 32'h1, 32'h2, 1'b0);
    chk_res("adc_hi", 32'h4, 1'b0, 4'b0000);

    send(3'd4, 32'h0, 32'h0, 1'b0);
    chk_res("clr0", 32'h0, 1'b0, 4'b0100);
    send(3'd2, 32'h0, 32'h7FFF_FFFF, 1'b0);
    chk_res("acc1", 32'h7FFF_FFFF, 1'b0, 4'b0000);
    chk("acc1_val", acc_value, 32'h7FFF_FFFF);
    send(3'd2, 32'h0, 32'h7FFF_FFFF, 1'b0);
    chk_res("acc2", SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFFE, 1'b0, SAT ? 4'b0001 : 4'b1001);
    chk("acc2_val", acc_value, SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFFE);
    send(3'd2, 32'h0, 32'h7FFF_FFFF, 1'b0);
    chk_res("acc3", SAT ? 32'h7FFF_FFFF : 32'h7FFF_FFFD, SAT ? 1'b0 : 1'b1,
            SAT ? 4'b0001 : 4'b0010);
    chk("acc3_val", acc_value, SAT ? 32'h7FFF_FFFF : 32'h7FFF_FFFD);
    send(3'd4, 32'h0, 32'h0, 1'b0);
    chk_res("clr1", 32'h0, 1'b0, 4'b0100);
    chk("clr1_acc", acc_value, 32'h0);

    // Backpressure: slot holds the CLR result while a beat waits.
    out_ready = 1'b0;
    op_mode = 3'd2; op_a = '0; op_b = 32'h5; op_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum_held", out_sum, 0);
      chk("bp_flags_held", out_flags, 4'b0100);
      chk("bp_acc_held", acc_value, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd2, 32'h0, 32'h5, 1'b0);
    chk("bp_acc_after", acc_value, 32'h5);

    t0 = $time;
    for (int i = 0; i < 20; i++) send(3'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
    chk("throughput_cycles", ($time - t0) / 10, 20);

    // Reset while the slot is full and carry_q is set.
    send(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_flags", out_flags, 0);
    chk("midrst_acc", acc_value, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'd3, 32'h0, 32'h0, 1'b0);
    chk_res("adc_after_rst", 32'h0, 1'b0, 4'b0100);

    // Randomized traffic with random consumer stalls and idle gaps.
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
